// File: rtl/apb_adp_pkg.sv
// Shared types for the APB slave bridge: FSM state, latched request payload
// and the channel-select width helper.
package apb_adp_pkg;

  // Payload fields are sized for the largest supported configuration;
  // users cast down to their own parameter widths.
  localparam int unsigned MAX_AW  = 32;
  localparam int unsigned MAX_DW  = 64;
  localparam int unsigned MAX_BW  = MAX_DW / 8;
  localparam int unsigned MAX_CHW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } apb_adp_state_e;

  typedef struct packed {
    logic [MAX_AW-1:0]  addr;
    logic [MAX_DW-1:0]  wdata;
    logic [MAX_BW-1:0]  wbe;
    logic               write;
    logic [MAX_CHW-1:0] ch;
  } apb_adp_req_t;

  // Channel-index width: at least one bit even for a single channel.
  function automatic int unsigned ch_sw(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/apb_adp_wdog.sv
// Ack watchdog for the APB bridge: cleared by load, counts while count_en,
// flags expire_c in the cycle that completes TO_CYCLES counted cycles.
//  clk, rst_n  clock, async active-low reset
//  load        clear the count (entry into REQ)
//  count_en    count this cycle (REQ or WAIT)
//  expire_c    combinational: this is the TO_CYCLES-th counted cycle
module apb_adp_wdog #(
  parameter int unsigned TO_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count_en,
  output logic expire_c
);

  localparam int unsigned CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] count;

  assign expire_c = count_en && (count == CW'(TO_CYCLES - 1));

  // Cycle counter; freezes once expired since the FSM leaves REQ/WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (count_en && !expire_c) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/apb_slave_bridge_mc.sv
// APB4 completer bridging one APB port to N_CH conduit channels selected by
// paddr[CH_AW +: CH_SW]. Each access issues a one-cycle strobe to the channel
// and holds the APB transfer with wait states until that channel acks.
// Optional macro APB_ADP_TIMEOUT_EN adds an ack timeout of TO_CYCLES cycles.
// Ports:
//  pclk, presetn                  clock, async active-low reset
//  paddr/psel/penable/pwrite/pwdata/pstrb   APB request
//  pready/prdata/pslverr          APB response (registered)
//  con_wr/con_rd                  one-hot channel strobes (one cycle)
//  con_addr/con_wdata/con_wbe     latched channel offset, data, byte enables
//  con_ack/con_err/con_rdata      per-channel completion, error, read data
module apb_slave_bridge_mc
  import apb_adp_pkg::*;
#(
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned A_WIDTH   = 12,
  parameter int unsigned N_CH      = 4,
  parameter int unsigned CH_AW     = 8,
  parameter int unsigned TO_CYCLES = 64
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic [A_WIDTH-1:0]      paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [D_WIDTH-1:0]      pwdata,
  input  logic [D_WIDTH/8-1:0]    pstrb,
  output logic                    pready,
  output logic [D_WIDTH-1:0]      prdata,
  output logic                    pslverr,
  output logic [N_CH-1:0]         con_wr,
  output logic [N_CH-1:0]         con_rd,
  output logic [CH_AW-1:0]        con_addr,
  output logic [D_WIDTH-1:0]      con_wdata,
  output logic [D_WIDTH/8-1:0]    con_wbe,
  input  logic [N_CH-1:0]         con_ack,
  input  logic [N_CH-1:0]         con_err,
  input  logic [N_CH*D_WIDTH-1:0] con_rdata
);

  localparam int unsigned CH_SW   = ch_sw(N_CH);
  localparam int unsigned B_WIDTH = D_WIDTH / 8;
  localparam int unsigned TOP_SH  = CH_AW + CH_SW;

  apb_adp_state_e     state;
  apb_adp_req_t       req_q;
  apb_adp_req_t       req_c;
  logic               setup_c;
  logic               dec_err_c;
  logic [CH_SW-1:0]   idx_c;
  logic [CH_SW-1:0]   ch_q;
  logic [N_CH-1:0]    onehot_c;
  logic               ack_c;
  logic               err_c;
  logic [D_WIDTH-1:0] rdata_c;
  logic               wd_load;
  logic               wd_en;
  logic               to_c;

  // Setup-phase decode and request payload to latch.
  always_comb begin
    setup_c   = psel & ~penable;
    idx_c     = paddr[CH_AW +: CH_SW];
    dec_err_c = (32'(idx_c) >= N_CH) || ((paddr >> TOP_SH) != '0);
    onehot_c  = N_CH'(1) << idx_c;
    req_c       = '0;
    req_c.addr  = MAX_AW'(paddr[CH_AW-1:0]);
    req_c.wdata = MAX_DW'(pwdata);
    req_c.wbe   = pwrite ? MAX_BW'(pstrb) : '0;
    req_c.write = pwrite;
    req_c.ch    = MAX_CHW'(idx_c);
  end

  assign ch_q = CH_SW'(req_q.ch);

  // Only the latched channel's ack/err/rdata are visible to the FSM.
  always_comb begin
    ack_c   = 1'b0;
    err_c   = 1'b0;
    rdata_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_q == CH_SW'(i)) begin
        ack_c   = con_ack[i];
        err_c   = con_err[i];
        rdata_c = con_rdata[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign con_addr  = CH_AW'(req_q.addr);
  assign con_wdata = D_WIDTH'(req_q.wdata);
  assign con_wbe   = B_WIDTH'(req_q.wbe);

  assign wd_load = (state == IDLE) && setup_c && !dec_err_c;
  assign wd_en   = (state == REQ) || (state == WAIT);

`ifdef APB_ADP_TIMEOUT_EN
  apb_adp_wdog #(
    .TO_CYCLES (TO_CYCLES)
  ) u_wdog (
    .clk      (pclk),
    .rst_n    (presetn),
    .load     (wd_load),
    .count_en (wd_en),
    .expire_c (to_c)
  );
`else
  assign to_c = 1'b0;
`endif

  // Transfer FSM with registered APB response and channel strobes.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      req_q   <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      con_wr  <= '0;
      con_rd  <= '0;
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      con_wr  <= '0;
      con_rd  <= '0;
      case (state)
        IDLE: begin
          if (setup_c) begin
            req_q <= req_c;
            if (dec_err_c) begin
              state   <= RESP;
              pready  <= 1'b1;
              pslverr <= 1'b1;
              prdata  <= '0;
            end else begin
              state <= REQ;
              if (pwrite) con_wr <= onehot_c;
              else        con_rd <= onehot_c;
            end
          end
        end
        REQ, WAIT: begin
          // Master abort wins; an ack beats a same-cycle timeout.
          if (!psel) begin
            state <= IDLE;
          end else if (ack_c) begin
            state   <= RESP;
            pready  <= 1'b1;
            pslverr <= err_c;
            prdata  <= req_q.write ? '0 : rdata_c;
          end else if (to_c) begin
            state   <= RESP;
            pready  <= 1'b1;
            pslverr <= 1'b1;
            prdata  <= '0;
          end else begin
            state <= WAIT;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_bridge_mc.sv
// Self-checking bench for apb_slave_bridge_mc (N_CH=4, CH_AW=8, D_WIDTH=32).
// Expected results come from a transaction-level model: decode error when
// addr >= N_CH*256, otherwise completion 2+delay cycles after setup.
// Timeout scenarios run only when APB_ADP_TIMEOUT_EN is defined.
module tb_apb_slave_bridge_mc;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NC = 4;
  localparam int CAW = 8;
  localparam int TO = 8;
  localparam int NEVER = 1000;
`ifdef APB_ADP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              pclk = 1'b0;
  logic              presetn;
  logic [AW-1:0]     paddr;
  logic              psel, penable, pwrite;
  logic [DW-1:0]     pwdata;
  logic [DW/8-1:0]   pstrb;
  logic              pready;
  logic [DW-1:0]     prdata;
  logic              pslverr;
  logic [NC-1:0]     con_wr, con_rd;
  logic [CAW-1:0]    con_addr;
  logic [DW-1:0]     con_wdata;
  logic [DW/8-1:0]   con_wbe;
  logic [NC-1:0]     con_ack, con_err;
  logic [NC*DW-1:0]  con_rdata;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] last_prdata = '0;

  apb_slave_bridge_mc #(
    .D_WIDTH(DW), .A_WIDTH(AW), .N_CH(NC), .CH_AW(CAW), .TO_CYCLES(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .con_wr(con_wr), .con_rd(con_rd), .con_addr(con_addr),
    .con_wdata(con_wdata), .con_wbe(con_wbe), .con_ack(con_ack),
    .con_err(con_err), .con_rdata(con_rdata)
  );

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC*DW-1:0] rand_rdata();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One APB transfer; the channel model acks `dly` cycles after the strobe.
  task automatic run_txn(input logic [AW-1:0] addr, input logic wr,
                         input logic [DW-1:0] wd, input logic [3:0] sb,
                         input int dly, input logic er, input logic [DW-1:0] rd,
                         input logic noise, input logic hold);
    int ch, oth, exp_lat, lat, nstb, stb_at;
    logic dec, terr;
    logic [NC-1:0] wv, rv, ewv, erv;
    logic [CAW-1:0] ca;
    logic [3:0] cbe;
    logic [DW-1:0] cwd, got_rd, exp_rd;
    logic got_err, exp_err;
    dec     = (int'(addr) >= NC * 256);
    ch      = int'(addr) / 256;
    oth     = (ch + 1) % NC;
    terr    = TO_EN && !dec && (dly >= TO);
    exp_lat = dec ? 1 : (terr ? 1 + TO : 2 + dly);
    exp_rd  = (dec || terr || wr) ? '0 : rd;
    exp_err = (dec || terr) ? 1'b1 : er;
    ewv     = (!dec && wr)  ? (NC'(1) << ch) : '0;
    erv     = (!dec && !wr) ? (NC'(1) << ch) : '0;
    lat = 0; nstb = 0; stb_at = 0;
    wv = '0; rv = '0; ca = '0; cbe = '0; cwd = '0; got_rd = '0; got_err = 1'b0;

    @(negedge pclk);
    paddr = addr; pwrite = wr; pwdata = wd; pstrb = sb;
    psel = 1'b1; penable = 1'b0;
    con_ack = '0; con_err = '0; con_rdata = rand_rdata();
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge pclk);
      penable = 1'b1;
      con_ack = '0; con_err = '0; con_rdata = rand_rdata();
      if (con_wr != '0 || con_rd != '0) begin
        nstb++;
        if (stb_at == 0) begin
          stb_at = k; wv = con_wr; rv = con_rd;
          ca = con_addr; cbe = con_wbe; cwd = con_wdata;
        end
      end
      if (stb_at != 0 && k - stb_at == dly) begin
        con_ack[ch] = 1'b1; con_err[ch] = er;
        con_rdata[ch*DW +: DW] = rd;
        if (noise) begin
          con_ack[oth] = 1'b1; con_err[oth] = ~er;
        end
      end
      if (pready) begin
        lat = k; got_rd = prdata; got_err = pslverr;
      end
    end
    psel = 1'b0; penable = 1'b0; con_ack = '0; con_err = '0;

    chk("latency", 64'(lat), 64'(exp_lat));
    chk("prdata", 64'(got_rd), 64'(exp_rd));
    chk("pslverr", 64'(got_err), 64'(exp_err));
    chk("con_wr", 64'(wv), 64'(ewv));
    chk("con_rd", 64'(rv), 64'(erv));
    chk("strobe_cycles", 64'(nstb), dec ? 64'd0 : 64'd1);
    if (!dec) begin
      chk("strobe_at", 64'(stb_at), 64'd1);
      chk("con_addr", 64'(ca), 64'(addr[CAW-1:0]));
      chk("con_wbe", 64'(cbe), wr ? 64'(sb) : 64'd0);
      chk("con_wdata", 64'(cwd), 64'(wd));
    end
    last_prdata = exp_rd;
    if (hold) begin
      @(negedge pclk);
      chk("idle_pready", 64'(pready), 64'd0);
      chk("idle_pslverr", 64'(pslverr), 64'd0);
      chk("prdata_hold", 64'(prdata), 64'(last_prdata));
    end
  endtask

  initial begin
    presetn = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pwdata = '0; pstrb = '0; con_ack = '0; con_err = '0; con_rdata = '0;
    repeat (2) @(negedge pclk);
    chk("rst_pready", 64'(pready), 64'd0);
    chk("rst_prdata", 64'(prdata), 64'd0);
    chk("rst_strobes", 64'({con_wr, con_rd}), 64'd0);
    chk("rst_con_wbe", 64'(con_wbe), 64'd0);
    presetn = 1'b1;

    // Write to ch1 with same-cycle ack, then delayed read from ch2.
    run_txn(12'h104, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    run_txn(12'h208, 1'b0, 32'h0, 4'h0, 5, 1'b0, 32'h12345678, 1'b0, 1'b1);

    // Reset asserted while waiting on a channel.
    @(negedge pclk);
    paddr = 12'h2A0; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'h3;
    psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    chk("rst_test_strobe", 64'(con_wr), 64'h4);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    chk("midrst_pready", 64'(pready), 64'd0);
    chk("midrst_prdata", 64'(prdata), 64'd0);
    chk("midrst_strobes", 64'({con_wr, con_rd}), 64'd0);
    chk("midrst_con", 64'({con_addr, con_wdata, con_wbe}), 64'd0);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; presetn = 1'b1;
    run_txn(12'h010, 1'b1, 32'h0BADF00D, 4'h5, 0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Out-of-range address, then ch3 read with a competing ch0 ack.
    run_txn(12'h800, 1'b0, 32'h0, 4'h0, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    run_txn(12'h3C4, 1'b0, 32'h0, 4'h0, 2, 1'b1, 32'hA5A55A5A, 1'b1, 1'b1);

    // Master abort while waiting: later ack must not complete anything.
    @(negedge pclk);
    paddr = 12'h304; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    con_ack = 4'b1000;
    chk("abort_pready0", 64'(pready), 64'd0);
    @(negedge pclk);
    con_ack = '0;
    chk("abort_pready1", 64'(pready), 64'd0);
    @(negedge pclk);
    chk("abort_pready2", 64'(pready), 64'd0);
    chk("abort_pslverr", 64'(pslverr), 64'd0);
    run_txn(12'h3FC, 1'b0, 32'h0, 4'h0, 1, 1'b0, 32'h600DCAFE, 1'b0, 1'b0);

`ifdef APB_ADP_TIMEOUT_EN
    // Channel never acks; then a late ack; then ack on the timeout cycle.
    run_txn(12'h020, 1'b0, 32'h0, 4'h0, NEVER, 1'b0, 32'h11111111, 1'b0, 1'b0);
    @(negedge pclk);
    con_ack = 4'b0001;
    chk("late_ack_pready0", 64'(pready), 64'd0);
    @(negedge pclk);
    con_ack = '0;
    chk("late_ack_pready1", 64'(pready), 64'd0);
    run_txn(12'h030, 1'b1, 32'h87654321, 4'hC, 0, 1'b0, 32'h0, 1'b0, 1'b1);
    run_txn(12'h140, 1'b0, 32'h0, 4'h0, TO - 1, 1'b0, 32'h77778888, 1'b0, 1'b1);
`endif

    // Randomized transfers, mixed back-to-back and idle gaps.
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      if ($urandom_range(7) == 0) a = AW'(12'h400 | 12'($urandom_range(12'hBFF)));
      else                        a = AW'($urandom_range(12'h3FF));
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(5)),
              1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    end

    repeat (2) @(negedge pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
